compare_search: RTL and testbench
=================================

# compare_search

Sequential binary-search engine that drives the operand side of a magnitude comparator (`compare`) and consumes its `AltB`/`AeqB`/`AgtB` result flags.
- It locates an unknown value `b`, such as a hidden threshold or a piece/row position held elsewhere, within a programmable inclusive range `[lo_init, hi_init]`.
- It presents one probe per clock on `probe` (wired to the comparator's `a`).
- It reports found/not-found, the located value, and the number of probes used.

## Interface
Parameters:
- `W`, default 8: operand width; must match the paired comparator's `W`.

Ports:
- `clock`, input, 1: sole clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: begin a search; honoured only in IDLE.
- `lo_init`, input, W: inclusive lower bound, captured on an accepted `start`.
- `hi_init`, input, W: inclusive upper bound, captured on an accepted `start`.
- `probe`, output, W: comparator `a` operand, driven from registers.
- `AltB`, input, 1: comparator flag meaning probe < target.
- `AeqB`, input, 1: comparator flag meaning probe == target.
- `AgtB`, input, 1: comparator flag meaning probe > target.
- `busy`, output, 1: high in SEARCH.
- `done`, output, 1: one-cycle pulse when a search ends.
- `found`, output, 1: valid from `done` until the next accepted `start`.
- `err`, output, 1: valid from `done` until the next accepted `start`; high if flags were not one-hot.
- `result`, output, W: value located; valid when `found`=1.
- `nprobes`, output, $clog2(W+2): number of probes issued in the last search.

## Operation
- States: IDLE, SEARCH, DONE.
- Internal registers `lo` and `hi` are W bits; no W+1 arithmetic is needed.
- Probe equation: `probe = lo + ((hi - lo) >> 1)`, computed in W bits; the subtraction cannot underflow while lo ≤ hi.

IDLE:
- `start`=1 with `lo_init` ≤ `hi_init`: capture `lo`/`hi`, clear `nprobes`, `found`, `err`; go to SEARCH.
- `start`=1 with `lo_init` > `hi_init`: go to DONE with `found`=0, `err`=0, `nprobes`=0.

SEARCH: each cycle, flags are sampled at the clock edge and `nprobes` increments. Flags are decoded as follows:
- Exactly `AeqB`: set `result`=probe, `found`=1; go to DONE.
- Exactly `AltB`, probe == hi: not found; go to DONE.
- Exactly `AltB`, otherwise: `lo` ← probe+1.
- Exactly `AgtB`, probe == lo: not found; go to DONE.
- Exactly `AgtB`, otherwise: `hi` ← probe−1.
- None or more than one flag high: set `err`=1, `found`=0; go to DONE.

DONE:
- `done`=1 for this one cycle; go to IDLE unconditionally.
- `start` in DONE is ignored.
- `start` while busy is ignored; `lo_init`/`hi_init` changes mid-search have no effect.

Bounds and reset:
- The search always terminates; a full range `0..2^W−1` needs at most W+1 probes.
- `reset` (including mid-search) forces IDLE in the same edge.
- Reset values: `busy`=0, `done`=0, `found`=0, `err`=0, `result`=0, `nprobes`=0, `probe`=0.

## Timing
- `start` is accepted at edge E0; probe k (k=1..N) is valid during cycle k after E0 and is sampled at the end of that cycle.
- `done` is high during cycle N+1; `busy` is high during cycles 1..N.
- Total latency is N+1 cycles from the accept edge to `done`; a new `start` is accepted no earlier than cycle N+2.
- `probe` changes only at clock edges, so the combinational comparator path is one cycle: probe register → compare → flag sampling.
- `probe` holds its last value outside SEARCH.

## Structure
- Shared package `search_pkg`: `typedef enum logic [1:0] {IDLE, SEARCH, DONE} search_state_t`.
- No RTL sub-module. The comparator stays external so the engine can pair with any flag source.
- The testbench instantiates `compare #(W)` with `a`=`probe` and `b`=target.

## Test plan
1. Range 0..255, target 100 → probes 127, 63, 95, 111, 103, 99, 101, 100; `found`=1, `result`=100, `nprobes`=8; `done` 9 cycles after `start`.
2. Range 0..255, target 255 → probes 127, 191, 223, 239, 247, 251, 253, 254, 255; `found`=1, `nprobes`=9 (W+1). Range 0..255, target 0 → ends at probe 0 after 8 probes; no wrap to 255.
3. Range 10..20, target 5 → probes 15, 12, 10; `found`=0, `err`=0, `nprobes`=3. Range 0..255, target 0 with the bench forcing `AgtB` at probe 0 → not found, no underflow.
4. `lo_init`=30, `hi_init`=20 → `done` the cycle after `start`; `found`=0, `nprobes`=0; `busy` never high.
5. Flags forced to 000 and then to 110 on the first probe → `err`=1, `found`=0, `nprobes`=1. Second `start` pulsed while busy → ignored; original search result unchanged.
6. `reset` asserted on the 3rd SEARCH cycle → next cycle IDLE with all outputs 0. A following `start` (range 0..255, target 100) completes exactly as in scenario 1.

Source files
------------

// File: rtl/search_pkg.sv
// Shared types for the binary-search engine.
//   search_state_t : IDLE (waiting for start), SEARCH (one probe per clock),
//                    DONE (one-cycle completion pulse).
package search_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } search_state_t;

endpackage

// File: rtl/compare_search_if.sv
// Request/response and comparator-flag bundle for compare_search.
//   start, lo_init, hi_init     : search request (master -> engine)
//   AltB, AeqB, AgtB            : comparator flags for the current probe (master -> engine)
//   probe                       : comparator 'a' operand (engine -> master)
//   busy, done, found, err      : status (engine -> master)
//   result, nprobes             : located value and probe count (engine -> master)
interface compare_search_if #(
  parameter int unsigned W = 8
);

  localparam int unsigned NW = $clog2(W + 2);

  logic          start;
  logic [W-1:0]  lo_init;
  logic [W-1:0]  hi_init;
  logic [W-1:0]  probe;
  logic          AltB;
  logic          AeqB;
  logic          AgtB;
  logic          busy;
  logic          done;
  logic          found;
  logic          err;
  logic [W-1:0]  result;
  logic [NW-1:0] nprobes;

  // Requester / flag source side.
  modport master (
    output start, lo_init, hi_init, AltB, AeqB, AgtB,
    input  probe, busy, done, found, err, result, nprobes
  );

  // Search engine side.
  modport slave (
    input  start, lo_init, hi_init, AltB, AeqB, AgtB,
    output probe, busy, done, found, err, result, nprobes
  );

endinterface

// File: rtl/compare.sv
// Combinational magnitude comparator used as the flag source for compare_search.
//   a, b             : operands (W bits, unsigned)
//   AltB, AeqB, AgtB : a<b, a==b, a>b
module compare #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         AltB,
  output logic         AeqB,
  output logic         AgtB
);

  assign AltB = (a <  b);
  assign AeqB = (a == b);
  assign AgtB = (a >  b);

endmodule

// File: rtl/compare_search.sv
// Sequential binary-search engine driving an external magnitude comparator.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : start/lo_init/hi_init request, probe out, AltB/AeqB/AgtB in,
//                  busy/done/found/err/result/nprobes status (all registered)
module compare_search
  import search_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic              clock,
  input logic              reset,
  compare_search_if.slave  bus
);

  localparam int unsigned NW = $clog2(W + 2);

  search_state_t state, state_nx;
  logic [W-1:0]  lo, lo_nx;
  logic [W-1:0]  hi, hi_nx;
  logic [W-1:0]  probe_q, probe_nx;
  logic [W-1:0]  result_q, result_nx;
  logic [NW-1:0] nprobes_q, nprobes_nx;
  logic          found_q, found_nx;
  logic          err_q, err_nx;
  logic          busy_q, done_q;
  logic [2:0]    flags;

  // Midpoint without W+1 bits: (h - l) never underflows while l <= h.
  function automatic logic [W-1:0] mid(input logic [W-1:0] l, input logic [W-1:0] h);
    return l + ((h - l) >> 1);
  endfunction

  assign flags = {bus.AltB, bus.AeqB, bus.AgtB};

  // State register and all datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      lo        <= '0;
      hi        <= '0;
      probe_q   <= '0;
      result_q  <= '0;
      nprobes_q <= '0;
      found_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      lo        <= lo_nx;
      hi        <= hi_nx;
      probe_q   <= probe_nx;
      result_q  <= result_nx;
      nprobes_q <= nprobes_nx;
      found_q   <= found_nx;
      err_q     <= err_nx;
      busy_q    <= (state_nx == SEARCH);
      done_q    <= (state_nx == DONE);
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_nx   = state;
    lo_nx      = lo;
    hi_nx      = hi;
    probe_nx   = probe_q;
    result_nx  = result_q;
    nprobes_nx = nprobes_q;
    found_nx   = found_q;
    err_nx     = err_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          found_nx   = 1'b0;
          err_nx     = 1'b0;
          nprobes_nx = '0;
          if (bus.lo_init <= bus.hi_init) begin
            lo_nx    = bus.lo_init;
            hi_nx    = bus.hi_init;
            probe_nx = mid(bus.lo_init, bus.hi_init);
            state_nx = SEARCH;
          end else begin
            state_nx = DONE;
          end
        end
      end

      SEARCH: begin
        nprobes_nx = nprobes_q + NW'(1);
        case (flags)
          3'b010: begin
            result_nx = probe_q;
            found_nx  = 1'b1;
            state_nx  = DONE;
          end
          3'b100: begin
            // probe below target; probe == hi means the range is exhausted
            if (probe_q == hi) begin
              state_nx = DONE;
            end else begin
              lo_nx    = probe_q + W'(1);
              probe_nx = mid(probe_q + W'(1), hi);
            end
          end
          3'b001: begin
            // probe above target; probe == lo means the range is exhausted
            if (probe_q == lo) begin
              state_nx = DONE;
            end else begin
              hi_nx    = probe_q - W'(1);
              probe_nx = mid(lo, probe_q - W'(1));
            end
          end
          default: begin
            err_nx   = 1'b1;
            found_nx = 1'b0;
            state_nx = DONE;
          end
        endcase
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.probe   = probe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.found   = found_q;
  assign bus.err     = err_q;
  assign bus.result  = result_q;
  assign bus.nprobes = nprobes_q;

endmodule

// File: tb/tb_compare_search.sv
// Directed testbench for compare_search paired with compare.
module tb_compare_search;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] target;
  logic         cmp_lt, cmp_eq, cmp_gt;
  logic [2:0]   flags;
  int           force_mode;   // 0: real flags, 1: AgtB at probe 0, 2: force_flags
  logic [2:0]   force_flags;

  int n_checks;
  int n_fail;
  int got_q[$];
  int exp_q[$];
  int saw_busy;
  int dcyc;

  compare_search_if #(.W(W)) bus ();

  compare_search #(.W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  compare #(.W(W)) cmp (
    .a    (bus.probe),
    .b    (target),
    .AltB (cmp_lt),
    .AeqB (cmp_eq),
    .AgtB (cmp_gt)
  );

  always_comb begin
    flags = {cmp_lt, cmp_eq, cmp_gt};
    if (force_mode == 1 && bus.probe == '0) flags = 3'b001;
    else if (force_mode == 2) flags = force_flags;
  end

  assign bus.AltB = flags[2];
  assign bus.AeqB = flags[1];
  assign bus.AgtB = flags[0];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one search; glitch>0 pulses a second start (0..10) in that cycle.
  task automatic run(input int lo, input int hi, input int tgt, input int glitch);
    target      = W'(tgt);
    bus.lo_init = W'(lo);
    bus.hi_init = W'(hi);
    bus.start   = 1'b1;
    @(posedge clock); #1;
    bus.start   = 1'b0;
    bus.lo_init = '0;
    bus.hi_init = '0;
    got_q.delete();
    dcyc     = -1;
    saw_busy = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == glitch) begin
        bus.start   = 1'b1;
        bus.hi_init = W'(10);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dcyc = c;
        break;
      end
      if (bus.busy) begin
        saw_busy = 1;
        got_q.push_back(int'(bus.probe));
      end
      @(posedge clock); #1;
    end
    bus.start = 1'b0;
  endtask

  // Compare the finished search against expectations, then one IDLE cycle later.
  task automatic check_search(input string tag, input int e_found, input int e_err,
                              input int e_result, input int e_n, input int e_dcyc);
    check({tag, ".done_cycle"}, dcyc, e_dcyc);
    check({tag, ".found"}, bus.found, e_found);
    check({tag, ".err"}, bus.err, e_err);
    if (e_found != 0) check({tag, ".result"}, bus.result, e_result);
    check({tag, ".nprobes"}, bus.nprobes, e_n);
    check({tag, ".nprobe_list"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s.probe%0d", tag, i + 1), got_q[i], exp_q[i]);
    if (dcyc < 0) return;
    @(posedge clock); #1;
    check({tag, ".done_pulse"}, bus.done, 0);
    check({tag, ".idle_busy"}, bus.busy, 0);
    check({tag, ".found_hold"}, bus.found, e_found);
    check({tag, ".err_hold"}, bus.err, e_err);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    force_mode  = 0;
    force_flags = 3'b000;
    target      = '0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.lo_init = '0;
    bus.hi_init = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.found", bus.found, 0);
    check("rst.err", bus.err, 0);
    check("rst.result", bus.result, 0);
    check("rst.nprobes", bus.nprobes, 0);
    check("rst.probe", bus.probe, 0);

    // 1: target 100 in full range
    exp_q = '{127, 63, 95, 111, 103, 99, 101, 100};
    run(0, 255, 100, 0);
    check_search("t100", 1, 0, 100, 8, 9);

    // 2: upper and lower edges of the range
    exp_q = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    run(0, 255, 255, 0);
    check_search("t255", 1, 0, 255, 9, 10);

    exp_q = '{127, 63, 31, 15, 7, 3, 1, 0};
    run(0, 255, 0, 0);
    check_search("t0", 1, 0, 0, 8, 9);

    // 3: target outside range, and forced AgtB at probe 0
    exp_q = '{15, 12, 10};
    run(10, 20, 5, 0);
    check_search("below", 0, 0, 0, 3, 4);

    force_mode = 1;
    exp_q = '{127, 63, 31, 15, 7, 3, 1, 0};
    run(0, 255, 0, 0);
    check_search("gt_at0", 0, 0, 0, 8, 9);
    force_mode = 0;

    // 4: inverted bounds
    exp_q.delete();
    run(30, 20, 25, 0);
    check_search("inv", 0, 0, 0, 0, 1);
    check("inv.never_busy", saw_busy, 0);

    // 5: non-one-hot flags
    force_mode  = 2;
    force_flags = 3'b000;
    exp_q = '{127};
    run(0, 255, 100, 0);
    check_search("flags000", 0, 1, 0, 1, 2);

    force_flags = 3'b110;
    run(0, 255, 100, 0);
    check_search("flags110", 0, 1, 0, 1, 2);
    force_mode = 0;

    // 5: start while busy is ignored
    exp_q = '{127, 63, 95, 111, 103, 99, 101, 100};
    run(0, 255, 100, 3);
    check_search("busy_start", 1, 0, 100, 8, 9);

    // 6: reset on the third SEARCH cycle
    target      = W'(100);
    bus.lo_init = W'(0);
    bus.hi_init = W'(255);
    bus.start   = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("midrst.busy_before", bus.busy, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst.busy", bus.busy, 0);
    check("midrst.done", bus.done, 0);
    check("midrst.found", bus.found, 0);
    check("midrst.err", bus.err, 0);
    check("midrst.result", bus.result, 0);
    check("midrst.nprobes", bus.nprobes, 0);
    check("midrst.probe", bus.probe, 0);

    exp_q = '{127, 63, 95, 111, 103, 99, 101, 100};
    run(0, 255, 100, 0);
    check_search("after_rst", 1, 0, 100, 8, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
